// File: rtl/pic_init_sequencer.sv
// 8259 command-word sequencer: walks ICW1..ICW4, routes A0=1 writes, and holds OCW state.
// Build option PIC_CASCADE_EN enables the ICW3 step, the icw3 register and the ms bit.
module pic_init_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       writeICW1,
  input  logic       writeICW2to4,
  input  logic       writeOCW1,
  input  logic       writeOCW2,
  input  logic       writeOCW3,
  input  logic [7:0] internalDataBus,
  output logic       init_done,
  output logic       ltim,
  output logic       sngl,
  output logic       ic4,
  output logic [4:0] vector_base,
  output logic [7:0] icw3,
  output logic       upm,
  output logic       aeoi,
  output logic       ms,
  output logic       buf_mode,
  output logic       sfnm,
  output logic [7:0] imr,
  output logic       ocw2_pulse,
  output logic       ocw2_r,
  output logic       ocw2_sl,
  output logic       ocw2_eoi,
  output logic [2:0] ocw2_level,
  output logic       rotate_aeoi,
  output logic       read_isr,
  output logic       poll_pulse,
  output logic       smm
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_ICW2, S_WAIT_ICW3, S_WAIT_ICW4, S_READY
  } state_t;

  state_t state_q, state_d;

  logic       init_done_q, init_done_d;
  logic       ltim_q, ltim_d, sngl_q, sngl_d, ic4_q, ic4_d;
  logic [4:0] vector_base_q, vector_base_d;
  logic       upm_q, upm_d, aeoi_q, aeoi_d, ms_q, ms_d;
  logic       buf_mode_q, buf_mode_d, sfnm_q, sfnm_d;
  logic [7:0] imr_q, imr_d;
  logic       ocw2_pulse_q, ocw2_pulse_d;
  logic       ocw2_r_q, ocw2_r_d, ocw2_sl_q, ocw2_sl_d, ocw2_eoi_q, ocw2_eoi_d;
  logic [2:0] ocw2_level_q, ocw2_level_d;
  logic       rotate_aeoi_q, rotate_aeoi_d;
  logic       read_isr_q, read_isr_d;
  logic       poll_pulse_q, poll_pulse_d;
  logic       smm_q, smm_d;
`ifdef PIC_CASCADE_EN
  logic [7:0] icw3_q, icw3_d;
`endif

  logic a0_wr;
  logic in_ready;

  // The A0=1 strobes arrive together; either one counts as the write.
  assign a0_wr    = writeICW2to4 | writeOCW1;
  assign in_ready = (state_q == S_READY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (writeICW1) begin
      state_d = S_WAIT_ICW2;
    end else if (a0_wr) begin
      case (state_q)
        S_WAIT_ICW2: begin
          state_d = ic4_q ? S_WAIT_ICW4 : S_READY;
`ifdef PIC_CASCADE_EN
          if (!sngl_q) state_d = S_WAIT_ICW3;
`endif
        end
        S_WAIT_ICW3: state_d = ic4_q ? S_WAIT_ICW4 : S_READY;
        S_WAIT_ICW4: state_d = S_READY;
        default:     state_d = state_q;
      endcase
    end
  end

  always_comb begin
    init_done_d   = (state_d == S_READY);
    ltim_d        = ltim_q;
    sngl_d        = sngl_q;
    ic4_d         = ic4_q;
    vector_base_d = vector_base_q;
    upm_d         = upm_q;
    aeoi_d        = aeoi_q;
    ms_d          = ms_q;
    buf_mode_d    = buf_mode_q;
    sfnm_d        = sfnm_q;
    imr_d         = imr_q;
    ocw2_pulse_d  = 1'b0;
    ocw2_r_d      = ocw2_r_q;
    ocw2_sl_d     = ocw2_sl_q;
    ocw2_eoi_d    = ocw2_eoi_q;
    ocw2_level_d  = ocw2_level_q;
    rotate_aeoi_d = rotate_aeoi_q;
    read_isr_d    = read_isr_q;
    poll_pulse_d  = 1'b0;
    smm_d         = smm_q;
`ifdef PIC_CASCADE_EN
    icw3_d        = icw3_q;
`endif
    if (writeICW1) begin
      ltim_d        = internalDataBus[3];
      sngl_d        = internalDataBus[1];
      ic4_d         = internalDataBus[0];
      imr_d         = 8'h00;
      smm_d         = 1'b0;
      read_isr_d    = 1'b0;
      rotate_aeoi_d = 1'b0;
      upm_d         = 1'b0;
      aeoi_d        = 1'b0;
      ms_d          = 1'b0;
      buf_mode_d    = 1'b0;
      sfnm_d        = 1'b0;
`ifdef PIC_CASCADE_EN
      icw3_d        = 8'h00;
`endif
    end else begin
      if (a0_wr) begin
        case (state_q)
          S_WAIT_ICW2: vector_base_d = internalDataBus[7:3];
`ifdef PIC_CASCADE_EN
          S_WAIT_ICW3: icw3_d = internalDataBus;
`endif
          S_WAIT_ICW4: begin
            sfnm_d     = internalDataBus[4];
            buf_mode_d = internalDataBus[3];
`ifdef PIC_CASCADE_EN
            ms_d       = internalDataBus[2];
`endif
            aeoi_d     = internalDataBus[1];
            upm_d      = internalDataBus[0];
          end
          S_READY:     imr_d = internalDataBus;
          default:     imr_d = imr_q;
        endcase
      end
      if (writeOCW2 && in_ready) begin
        ocw2_pulse_d = 1'b1;
        ocw2_r_d     = internalDataBus[7];
        ocw2_sl_d    = internalDataBus[6];
        ocw2_eoi_d   = internalDataBus[5];
        ocw2_level_d = internalDataBus[2:0];
        // Only the non-specific, non-EOI forms touch the rotate-on-AEOI flag.
        if (internalDataBus[6:5] == 2'b00) rotate_aeoi_d = internalDataBus[7];
      end
      if (writeOCW3 && in_ready) begin
        if (internalDataBus[1]) read_isr_d = internalDataBus[0];
        if (internalDataBus[6]) smm_d = internalDataBus[5];
        poll_pulse_d = internalDataBus[2];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_done_q   <= 1'b0;
      ltim_q        <= 1'b0;
      sngl_q        <= 1'b0;
      ic4_q         <= 1'b0;
      vector_base_q <= 5'd0;
      upm_q         <= 1'b0;
      aeoi_q        <= 1'b0;
      ms_q          <= 1'b0;
      buf_mode_q    <= 1'b0;
      sfnm_q        <= 1'b0;
      imr_q         <= 8'h00;
      ocw2_pulse_q  <= 1'b0;
      ocw2_r_q      <= 1'b0;
      ocw2_sl_q     <= 1'b0;
      ocw2_eoi_q    <= 1'b0;
      ocw2_level_q  <= 3'd0;
      rotate_aeoi_q <= 1'b0;
      read_isr_q    <= 1'b0;
      poll_pulse_q  <= 1'b0;
      smm_q         <= 1'b0;
    end else begin
      init_done_q   <= init_done_d;
      ltim_q        <= ltim_d;
      sngl_q        <= sngl_d;
      ic4_q         <= ic4_d;
      vector_base_q <= vector_base_d;
      upm_q         <= upm_d;
      aeoi_q        <= aeoi_d;
      ms_q          <= ms_d;
      buf_mode_q    <= buf_mode_d;
      sfnm_q        <= sfnm_d;
      imr_q         <= imr_d;
      ocw2_pulse_q  <= ocw2_pulse_d;
      ocw2_r_q      <= ocw2_r_d;
      ocw2_sl_q     <= ocw2_sl_d;
      ocw2_eoi_q    <= ocw2_eoi_d;
      ocw2_level_q  <= ocw2_level_d;
      rotate_aeoi_q <= rotate_aeoi_d;
      read_isr_q    <= read_isr_d;
      poll_pulse_q  <= poll_pulse_d;
      smm_q         <= smm_d;
    end
  end

`ifdef PIC_CASCADE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) icw3_q <= 8'h00;
    else     icw3_q <= icw3_d;
  end
  assign icw3 = icw3_q;
`else
  assign icw3 = 8'h00;
`endif

  assign init_done   = init_done_q;
  assign ltim        = ltim_q;
  assign sngl        = sngl_q;
  assign ic4         = ic4_q;
  assign vector_base = vector_base_q;
  assign upm         = upm_q;
  assign aeoi        = aeoi_q;
  assign ms          = ms_q;
  assign buf_mode    = buf_mode_q;
  assign sfnm        = sfnm_q;
  assign imr         = imr_q;
  assign ocw2_pulse  = ocw2_pulse_q;
  assign ocw2_r      = ocw2_r_q;
  assign ocw2_sl     = ocw2_sl_q;
  assign ocw2_eoi    = ocw2_eoi_q;
  assign ocw2_level  = ocw2_level_q;
  assign rotate_aeoi = rotate_aeoi_q;
  assign read_isr    = read_isr_q;
  assign poll_pulse  = poll_pulse_q;
  assign smm         = smm_q;

endmodule
